// File: rtl/simmem_rank_scheduler.sv
// simmem_rank_scheduler: arbitrates write/read beat requests onto one rank with a row-buffer cost model
module simmem_rank_scheduler #(
  parameter int IidWidth          = 6,
  parameter int AddrWidth         = 32,
  parameter int RowBufferLenWidth = 10,
  parameter int DelayWidth        = 6,
  parameter int RowHitCost        = 2,
  parameter int ActivationCost    = 3,
  parameter int PrechargeCost     = 4,
  parameter int StarveLimit       = 4,
  parameter int RowCloseIdle      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 w_req_valid_i,
  output logic                 w_req_ready_o,
  input  logic [IidWidth-1:0]  w_req_iid_i,
  input  logic [AddrWidth-1:0] w_req_addr_i,
  input  logic                 r_req_valid_i,
  output logic                 r_req_ready_o,
  input  logic [IidWidth-1:0]  r_req_iid_i,
  input  logic [AddrWidth-1:0] r_req_addr_i,
  output logic                 done_valid_o,
  output logic                 done_is_write_o,
  output logic [IidWidth-1:0]  done_iid_o,
  output logic                 busy_o,
  output logic                 row_open_o
);
  localparam int RowW = AddrWidth - RowBufferLenWidth;
  localparam int StW  = $clog2(StarveLimit + 1);
  localparam int IdW  = $clog2(RowCloseIdle + 2);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [DelayWidth-1:0] CostHit    = DelayWidth'(RowHitCost);
  localparam logic [DelayWidth-1:0] CostClosed = DelayWidth'(RowHitCost + ActivationCost);
  localparam logic [DelayWidth-1:0] CostMiss   = DelayWidth'(RowHitCost + ActivationCost + PrechargeCost);
  localparam logic [StW-1:0] StarveMax = StW'(StarveLimit);
  localparam logic [IdW-1:0] CloseAt   = IdW'(RowCloseIdle == 0 ? 0 : RowCloseIdle - 1);

  if (RowHitCost + ActivationCost + PrechargeCost >= (1 << DelayWidth) || RowHitCost < 1 || StarveLimit < 1) begin : g_bad_cfg
    $error("simmem_rank_scheduler: invalid cost/starve configuration");
  end

  logic [0:0]            state_q;
  logic [DelayWidth-1:0] cnt_q;
  logic [IidWidth-1:0]   iid_q;
  logic                  side_w_q;
  logic                  row_open_q;
  logic [RowW-1:0]       open_row_q;
  logic                  last_served_w_q;
  logic [StW-1:0]        w_starve_q;
  logic [StW-1:0]        r_starve_q;
  logic [IdW-1:0]        idle_cnt_q;

  logic [RowW-1:0]       w_row;
  logic [RowW-1:0]       r_row;
  logic [DelayWidth-1:0] w_cost;
  logic [DelayWidth-1:0] r_cost;
  logic                  idle;
  logic                  any_valid;
  logic                  sel_w;
  logic                  accept;
  logic                  row_close;
  logic                  unused_addr;

  assign w_row       = w_req_addr_i[AddrWidth-1:RowBufferLenWidth];
  assign r_row       = r_req_addr_i[AddrWidth-1:RowBufferLenWidth];
  assign unused_addr = ^{w_req_addr_i[RowBufferLenWidth-1:0], r_req_addr_i[RowBufferLenWidth-1:0]};
  assign w_cost      = !row_open_q ? CostClosed : (w_row == open_row_q ? CostHit : CostMiss);
  assign r_cost      = !row_open_q ? CostClosed : (r_row == open_row_q ? CostHit : CostMiss);
  assign idle        = state_q == IDLE;
  assign any_valid   = w_req_valid_i || r_req_valid_i;
  assign accept      = idle && any_valid;
  // Write wins when alone, when starved, on lower cost, or on a tie after a read was last served.
  assign sel_w       = w_req_valid_i && (!r_req_valid_i || w_starve_q >= StarveMax ||
                       (r_starve_q < StarveMax && (w_cost < r_cost || (w_cost == r_cost && !last_served_w_q))));
  assign w_req_ready_o = accept && sel_w;
  assign r_req_ready_o = accept && !sel_w;
  assign row_close   = idle && !any_valid && row_open_q && RowCloseIdle != 0 && idle_cnt_q == CloseAt;
  assign done_valid_o    = state_q == BUSY && cnt_q == '0;
  assign done_is_write_o = side_w_q;
  assign done_iid_o      = iid_q;
  assign busy_o          = state_q == BUSY;
  assign row_open_o      = row_open_q;

  // Rank FSM, busy countdown and row-buffer state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      iid_q           <= '0;
      side_w_q        <= 1'b0;
      row_open_q      <= 1'b0;
      open_row_q      <= '0;
      last_served_w_q <= 1'b0;
    end else if (accept) begin
      state_q         <= BUSY;
      cnt_q           <= (sel_w ? w_cost : r_cost) - DelayWidth'(1);
      iid_q           <= sel_w ? w_req_iid_i : r_req_iid_i;
      side_w_q        <= sel_w;
      row_open_q      <= 1'b1;
      open_row_q      <= sel_w ? w_row : r_row;
      last_served_w_q <= sel_w;
    end else if (!idle) begin
      cnt_q   <= cnt_q == '0 ? cnt_q : cnt_q - DelayWidth'(1);
      state_q <= cnt_q == '0 ? IDLE : BUSY;
    end else if (row_close) begin
      row_open_q <= 1'b0;
    end
  end

  // Starvation counters: winner clears, a valid loser counts up to the limit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_starve_q <= '0;
      r_starve_q <= '0;
    end else if (accept) begin
      w_starve_q <= sel_w ? '0 : (w_req_valid_i && w_starve_q != StarveMax ? w_starve_q + StW'(1) : w_starve_q);
      r_starve_q <= !sel_w ? '0 : (r_req_valid_i && r_starve_q != StarveMax ? r_starve_q + StW'(1) : r_starve_q);
    end
  end

  // Idle counter that closes an open row after a quiet stretch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) idle_cnt_q <= '0;
    else if (!idle || any_valid) idle_cnt_q <= '0;
    else if (row_open_q) idle_cnt_q <= row_close ? '0 : idle_cnt_q + IdW'(1);
  end
endmodule

// File: tb/tb_simmem_rank_scheduler.sv
// tb_simmem_rank_scheduler: directed scoreboard bench for the rank scheduler
module tb_simmem_rank_scheduler;
  typedef struct {
    bit         w;
    logic [5:0] iid;
    int         cost;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        w_req_valid = 1'b0;
  logic        w_req_ready;
  logic [5:0]  w_req_iid = '0;
  logic [31:0] w_req_addr = '0;
  logic        r_req_valid = 1'b0;
  logic        r_req_ready;
  logic [5:0]  r_req_iid = '0;
  logic [31:0] r_req_addr = '0;
  logic        done_valid;
  logic        done_is_write;
  logic [5:0]  done_iid;
  logic        busy;
  logic        row_open;

  int    nvec = 0;
  int    nerr = 0;
  item_t sb[$];

  simmem_rank_scheduler #(.StarveLimit(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .w_req_valid_i(w_req_valid), .w_req_ready_o(w_req_ready), .w_req_iid_i(w_req_iid), .w_req_addr_i(w_req_addr),
    .r_req_valid_i(r_req_valid), .r_req_ready_o(r_req_ready), .r_req_iid_i(r_req_iid), .r_req_addr_i(r_req_addr),
    .done_valid_o(done_valid), .done_is_write_o(done_is_write), .done_iid_o(done_iid),
    .busy_o(busy), .row_open_o(row_open)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    w_req_valid = 1'b0;
    r_req_valid = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic arb(input bit wv, input logic [31:0] wa, input logic [5:0] wi,
                     input bit rv, input logic [31:0] ra, input logic [5:0] ri,
                     input bit exp_w, input int cost);
    w_req_valid = wv; w_req_addr = wa; w_req_iid = wi;
    r_req_valid = rv; r_req_addr = ra; r_req_iid = ri;
    @(negedge clk);
    chk("w_ready", 32'(w_req_ready), 32'(exp_w));
    chk("r_ready", 32'(r_req_ready), 32'(!exp_w));
    sb.push_back('{w: exp_w, iid: exp_w ? wi : ri, cost: cost});
    @(posedge clk);
    #1;
    w_req_valid = 1'b0;
    r_req_valid = 1'b0;
  endtask

  task automatic drain();
    item_t e;
    int    n = 0;
    bit    got = 1'b0;
    chk("sb_pending", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      while (!got && n < 40) begin
        @(negedge clk);
        n++;
        if (done_valid) got = 1'b1;
        else begin
          @(posedge clk);
          #1;
        end
      end
      chk("done_seen", 32'(got), 32'd1);
      chk("latency", 32'(n), 32'(e.cost));
      chk("done_is_write", 32'(done_is_write), 32'(e.w));
      chk("done_iid", 32'(done_iid), 32'(e.iid));
      chk("busy_at_done", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int pulses;
    do_reset();
    #2;
    chk("rst_w_ready", 32'(w_req_ready), 32'd0);
    chk("rst_r_ready", 32'(r_req_ready), 32'd0);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_done_is_write", 32'(done_is_write), 32'd0);
    chk("rst_done_iid", 32'(done_iid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_row_open", 32'(row_open), 32'd0);
    #1;
    // closed row: write 0x1000 costs 5; ready stays low while busy
    arb(1, 32'h1000, 6'd3, 0, 32'h0, 6'd0, 1, 5);
    #2;
    chk("row_open_c1", 32'(row_open), 32'd1);
    chk("busy_c1", 32'(busy), 32'd1);
    w_req_valid = 1'b1;
    #1;
    chk("w_ready_busy", 32'(w_req_ready), 32'd0);
    w_req_valid = 1'b0;
    drain();
    arb(0, 32'h0, 6'd0, 1, 32'h1004, 6'd7, 0, 2);
    drain();
    arb(0, 32'h0, 6'd0, 1, 32'h8000, 6'd9, 0, 9);
    drain();
    // valid on the close-threshold cycle: still priced as an open-row hit
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    arb(1, 32'h8004, 6'd10, 0, 32'h0, 6'd0, 1, 2);
    drain();
    #2;
    chk("row_open_after_thresh", 32'(row_open), 32'd1);
    // sixteen quiet cycles close the row
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 16) chk("row_open_idle16", 32'(row_open), 32'd1);
      @(posedge clk);
      #1;
    end
    #2;
    chk("row_closed_idle17", 32'(row_open), 32'd0);
    arb(1, 32'h1000, 6'd11, 0, 32'h0, 6'd0, 1, 5);
    drain();
    // simultaneous requests from reset: tie to write, then write by cost, then read forced by starvation
    do_reset();
    arb(1, 32'h1000, 6'd1, 1, 32'h2000, 6'd2, 1, 5);
    drain();
    arb(1, 32'h1000, 6'd4, 1, 32'h2000, 6'd5, 1, 2);
    drain();
    arb(1, 32'h1000, 6'd6, 1, 32'h2000, 6'd8, 0, 9);
    drain();
    // starvation with write hitting the open row and read missing
    do_reset();
    arb(1, 32'h1000, 6'd12, 0, 32'h0, 6'd0, 1, 5);
    drain();
    arb(1, 32'h1000, 6'd13, 1, 32'h8000, 6'd14, 1, 2);
    drain();
    arb(1, 32'h1000, 6'd15, 1, 32'h8000, 6'd14, 1, 2);
    drain();
    arb(1, 32'h1000, 6'd16, 1, 32'h8000, 6'd14, 0, 9);
    drain();
    // reset mid-busy drops the pending completion
    arb(1, 32'h1000, 6'd20, 0, 32'h0, 6'd0, 1, 9);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done_valid), 32'd0);
    chk("rst_mid_row_open", 32'(row_open), 32'd0);
    sb.delete();
    #5 rst_ni = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      pulses += int'(done_valid);
    end
    chk("no_done_after_rst", 32'(pulses), 32'd0);
    @(posedge clk);
    #1;
    arb(1, 32'h1000, 6'd21, 0, 32'h0, 6'd0, 1, 5);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/simmem_rank_scheduler.md
# simmem_rank_scheduler

Single-rank access scheduler for the simulated memory controller. It takes write and read burst-beat requests, each tagged with an internal identifier (iid), and arbitrates them onto one shared rank. It models the row buffer (open/closed, open row index) to price each request as row hit, row closed or row miss. It holds the rank busy for that many cycles, then pulses a completion carrying the iid, which upstream logic turns into write-response / read-data release enables.

## Interface
- IidWidth, 6: width of the internal identifier.
- AddrWidth, 32: width of the request address.
- RowBufferLenWidth, 10: log2 of row length in bytes; row index = addr[AddrWidth-1:RowBufferLenWidth].
- DelayWidth, 6: width of the cost and delay counter.
- RowHitCost, 2: cycles for a row hit; must be >= 1.
- ActivationCost, 3: extra cycles when the row is closed.
- PrechargeCost, 4: extra cycles when a different row is open.
- StarveLimit, 4: consecutive lost arbitrations after which a side is forced to win; must be >= 1.
- RowCloseIdle, 16: idle cycles with no valid request before the open row is closed; 0 disables closing.

- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- w_req_valid_i  in  1  write request valid.
- w_req_ready_o  out  1  write request accepted this cycle.
- w_req_iid_i  in  IidWidth  write iid.
- w_req_addr_i  in  AddrWidth  write address.
- r_req_valid_i  in  1  read request valid.
- r_req_ready_o  out  1  read request accepted this cycle.
- r_req_iid_i  in  IidWidth  read iid.
- r_req_addr_i  in  AddrWidth  read address.
- done_valid_o  out  1  one-cycle completion pulse; no back-pressure.
- done_is_write_o  out  1  completion belongs to the write side.
- done_iid_o  out  IidWidth  iid of the completed request.
- busy_o  out  1  rank occupied (state BUSY).
- row_open_o  out  1  row buffer open (registered state).

## Operation
- FSM with two states, IDLE and BUSY; reset state is IDLE.
- Cost for addr a:
  - row_open_q && row(a) == open_row_q: RowHitCost.
  - !row_open_q: RowHitCost+ActivationCost.
  - Otherwise: RowHitCost+ActivationCost+PrechargeCost.
  - The sum must fit DelayWidth (elaboration assertion).
- Arbitration applies in IDLE only. Winner selection, first matching rule wins:
  - Only one side valid: that side wins.
  - One side's starve counter >= StarveLimit: that side wins.
  - Lower cost wins.
  - Tie: the side opposite last_served_w_q wins. last_served_w_q resets to 0, so the first tie goes to write.
- Ready behaviour:
  - ready_o is combinational and asserted only for the winner, only while its valid is high and the FSM is in IDLE.
  - The loser's ready is 0; both readies are 0 in BUSY.
- On accept:
  - Latch iid and side; load cnt_q = cost-1; go to BUSY.
  - Set row_open_q = 1 and open_row_q = row(addr).
  - Set last_served_w_q = winner is write.
  - Winner's starve counter clears.
  - Loser's starve counter increments (saturating) only if the loser was valid.
- BUSY: cnt_q decrements each cycle. When cnt_q == 0:
  - done_valid_o = 1 with the latched iid and side.
  - Next state is IDLE.
- Idle close:
  - In IDLE with no valid input and row_open_q, idle_cnt_q increments.
  - When it reaches RowCloseIdle-1, row_open_q clears on the next edge.
  - idle_cnt_q clears on any valid input, any accept, or in BUSY.
- Inputs are sampled only at acceptance; valid may drop without effect while ready is low.

## Timing
- Reset values: ready 0 (no valid), done_valid_o 0, done_is_write_o 0, done_iid_o 0, busy_o 0, row_open_o 0. All counters 0; open_row_q 0.
- Completion latency: an accept in cycle T gives busy_o high in T+1..T+cost and done_valid_o in cycle T+cost.
- The next accept is possible in T+cost+1, so throughput is one request per cost+1 cycles.
- The row state updates at the accept edge. Costs seen in BUSY already reflect the new row.
- Reset asserted mid-BUSY: immediate return to reset values; the pending completion is dropped and never emitted.
- Valid asserted in the same cycle idle_cnt_q hits the close threshold: the request is priced with the row still open, and row_open_q does not clear.
- Starve counters saturate at StarveLimit.

## Test plan
- Write addr 0x1000, iid 3, at cycle 0 after reset (row closed) -> w_req_ready_o=1 at cycle 0; done_valid_o=1, done_is_write_o=1, done_iid_o=3 at cycle 5; row_open_o=1 from cycle 1.
- Then read addr 0x1004, iid 7 -> cost 2: done two cycles after accept. Then read addr 0x8000 -> cost 9.
- Write 0x1000 and read 0x2000 valid together from reset (both cost 5) -> write wins. Repeating both (row now 0x1000-row: write hit 2, read miss 9) -> write keeps winning on cost.
- StarveLimit=2, write always valid to the open row, read always valid to another row -> read loses twice, third arbitration r_req_ready_o=1 with cost 9.
- Row open, no valid for 16 cycles -> row_open_o falls after the 16th idle cycle; next write 0x1000 costs 5.
- Accept write (cost 9), assert rst_ni=0 at cycle 4 -> busy_o=0 immediately, no done_valid_o after release; first post-reset request costs 5.
